alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
// - ALU reservation station: receiving end of the dispatcher's ALU port (ALUen/ALUop/ALUoperand*/ALUtag*/ALUnameW).
// - Holds dispatched ALU ops until both operands are valid. Snoops both CDBs (ALU, LS) for operand wakeup.
// - Issues one ready op per cycle to the ALU. Reports per-entry free status back to the dispatcher's free-tag table.
// PARAMETERS
// - RS_SIZE   8        number of entries (= `rsSize)
// - IDX_W     3        entry index width; entry index = tag[IDX_W-1:0]
// - TAG_W     5        tag width: {reserved, prefix, idx}
// - TAG_FREE  5'b10000 tag value meaning "operand valid"; never equals a real tag
// - DATA_W    32       operand/result width
// - NAME_W    5        architectural register name width
// - OP_W      6        opcode width
// PORTS
// - clk             in   1        clock, rising edge
// - rst             in   1        asynchronous reset, active-low
// - inEn            in   1        dispatch valid (dispatcher ALUen)
// - inOp            in   OP_W     opcode
// - inDataO/inDataT in   DATA_W   operand values (meaningful only when matching tag == TAG_FREE)
// - inTagO/inTagT   in   TAG_W    operand producer tags
// - inTagW          in   TAG_W    destination tag; low IDX_W bits select the entry
// - inNameW         in   NAME_W   destination register name
// - cdbAluEn/cdbLsEn      in 1       CDB broadcast valid (ALU result / load result)
// - cdbAluTag/cdbLsTag    in TAG_W   broadcast tags
// - cdbAluData/cdbLsData  in DATA_W  broadcast data
// - freeStatus      out  RS_SIZE  bit i = 1 when entry i is empty
// - outEn           out  1        issue valid to ALU
// - outOp/outDataO/outDataT/outTagW/outNameW  out  as inputs   issued operation
// - flush           in   1        only with ALU_RS_FLUSH_EN
// BEHAVIOUR
// - Reset (rst=0, async): all busy=0, freeStatus=all 1s, outEn=0, outOp/outData*=0, outTagW=TAG_FREE, outNameW=0.
// - Entry state: busy, op, dataO, tagO, dataT, tagT, tagW, nameW.
// - Dispatch, edge with inEn=1: entry[inTagW idx] <= inputs; busy<=1.
//   - Same-edge bypass: if inTagX equals a valid CDB tag, store the CDB data and set tagX=TAG_FREE.
// - Wakeup, each edge: for every busy entry and each operand with tagX==cdbAluTag&&cdbAluEn (or LS equivalent),
//   dataX<=CDB data, tagX<=TAG_FREE. ALU CDB takes priority if both buses match (protocol says never happens).
// - Ready = busy && tagO==TAG_FREE && tagT==TAG_FREE. Computed from registered state only; no same-cycle wakeup-to-issue.
// - Issue, each edge:
//   - select lowest-index ready entry;
//   - outputs registered from it, outEn<=1, entry busy<=0.
//   - With no ready entry: outEn<=0, other outputs hold.
// - ALU accepts one op per cycle; no backpressure.
// - Latency: dispatch of ready op at edge N -> outEn=1 after edge N+1.
//   Operand broadcast at edge N -> issue after edge N+1.
// - freeStatus = ~busy, combinational from registers; freed entry visible after the issue edge.
// - Dispatch to a busy entry is a protocol violation: entry is overwritten; sim assertion fires.
// - Full RS: freeStatus=0; the dispatcher stalls. The RS takes no action.
// - Reset asserted mid-operation: all entries dropped immediately; no issue on the next edge.
// CONFIGURATION
// - ALU_RS_FLUSH_EN defined:
//   - adds port flush; flush=1 at an edge clears all busy and forces outEn<=0;
//   - flush overrides a same-edge dispatch and same-edge issue (mispredict recovery).
// - ALU_RS_FLUSH_EN undefined: no flush port; entries leave only by issue or reset.
// TESTING
// - Ready dispatch: inEn, tags=TAG_FREE, dataO=5, dataT=7, op ADD, tagW=5'b00011 -> freeStatus[3]=0 after edge;
//   outEn=1, outDataO=5, outDataT=7, outTagW=3 one edge later; freeStatus[3]=1 again.
// - Wakeup: dispatch tagO=5'b01010 (LS entry 2) into entry 0; next cycle cdbLsEn, tag 01010, data 0xDEAD ->
//   entry 0 issues on the following edge with outDataO=0xDEAD.
// - Same-edge bypass: dispatch tagT=5'b00001 while cdbAluEn with tag 00001, data 42 -> issues next edge, outDataT=42.
// - Priority: entries 2 and 6 both become ready on the same edge -> entry 2 issues, then entry 6 one cycle later;
//   outEn stays high for 2 cycles.
// - Fill and drain: 8 dispatches with unready tags -> freeStatus=8'h00. Broadcast all tags -> 8 consecutive issues in
//   index order; freeStatus returns to 8'hFF.
// - Reset/flush: 3 busy entries, rst low mid-cycle -> freeStatus=8'hFF and outEn=0 immediately.
//   With ALU_RS_FLUSH_EN, flush=1 gives the same result after the edge.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station; holds dispatched ops until both operands are valid, snoops the ALU and LS CDBs,
// issues the lowest-index ready entry each cycle and reports per-entry free status to the dispatcher.
// Ports: clk, rst (async, active-low); dispatch inEn/inOp/inData*/inTag*/inNameW; CDBs cdbAlu*/cdbLs*;
// freeStatus (bit i = entry i empty); issue outEn/outOp/outDataO/outDataT/outTagW/outNameW.
// Optional: ALU_RS_FLUSH_EN adds input flush, which empties every entry and suppresses issue at that edge.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 5,
  parameter int DATA_W = 32,
  parameter int NAME_W = 5,
  parameter int OP_W = 6,
  parameter logic [TAG_W-1:0] TAG_FREE = {1'b1, {(TAG_W-1){1'b0}}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inEn,
  input  logic [OP_W-1:0]    inOp,
  input  logic [DATA_W-1:0]  inDataO,
  input  logic [DATA_W-1:0]  inDataT,
  input  logic [TAG_W-1:0]   inTagO,
  input  logic [TAG_W-1:0]   inTagT,
  input  logic [TAG_W-1:0]   inTagW,
  input  logic [NAME_W-1:0]  inNameW,
  input  logic               cdbAluEn,
  input  logic [TAG_W-1:0]   cdbAluTag,
  input  logic [DATA_W-1:0]  cdbAluData,
  input  logic               cdbLsEn,
  input  logic [TAG_W-1:0]   cdbLsTag,
  input  logic [DATA_W-1:0]  cdbLsData,
`ifdef ALU_RS_FLUSH_EN
  input  logic               flush,
`endif
  output logic [RS_SIZE-1:0] freeStatus,
  output logic               outEn,
  output logic [OP_W-1:0]    outOp,
  output logic [DATA_W-1:0]  outDataO,
  output logic [DATA_W-1:0]  outDataT,
  output logic [TAG_W-1:0]   outTagW,
  output logic [NAME_W-1:0]  outNameW
);
  logic [RS_SIZE-1:0] busy, ready;
  logic [OP_W-1:0] op_q [RS_SIZE];
  logic [DATA_W-1:0] data_o [RS_SIZE];
  logic [DATA_W-1:0] data_t [RS_SIZE];
  logic [TAG_W-1:0] tag_o [RS_SIZE];
  logic [TAG_W-1:0] tag_t [RS_SIZE];
  logic [TAG_W-1:0] tag_w [RS_SIZE];
  logic [NAME_W-1:0] name_w [RS_SIZE];
  logic [IDX_W-1:0] sel, in_idx;
  logic issue, kill;
  // A matching broadcast turns an operand valid; ALU bus wins if both match.
  function automatic logic [TAG_W+DATA_W-1:0] snoop(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    return (cdbAluEn && t == cdbAluTag) ? {TAG_FREE, cdbAluData} :
           (cdbLsEn && t == cdbLsTag) ? {TAG_FREE, cdbLsData} : {t, d};
  endfunction
`ifdef ALU_RS_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif
  assign in_idx = inTagW[IDX_W-1:0];
  assign freeStatus = ~busy;
  assign issue = |ready && !kill;
  // Downward scan so the last hit, i.e. the lowest ready index, is selected.
  always_comb begin
    ready = '0;
    sel = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready[i] = busy[i] && tag_o[i] == TAG_FREE && tag_t[i] == TAG_FREE;
      if (ready[i]) sel = IDX_W'(i);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      outEn <= 1'b0;
      outOp <= '0;
      outDataO <= '0;
      outDataT <= '0;
      outTagW <= TAG_FREE;
      outNameW <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i] <= '0;
        data_o[i] <= '0;
        data_t[i] <= '0;
        tag_o[i] <= TAG_FREE;
        tag_t[i] <= TAG_FREE;
        tag_w[i] <= TAG_FREE;
        name_w[i] <= '0;
      end
    end else begin
      outEn <= issue;
      if (issue) begin
        outOp <= op_q[sel];
        outDataO <= data_o[sel];
        outDataT <= data_t[sel];
        outTagW <= tag_w[sel];
        outNameW <= name_w[sel];
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          {tag_o[i], data_o[i]} <= snoop(tag_o[i], data_o[i]);
          {tag_t[i], data_t[i]} <= snoop(tag_t[i], data_t[i]);
        end
        if (kill) busy[i] <= 1'b0;
        else if (inEn && in_idx == IDX_W'(i)) begin
          busy[i] <= 1'b1;
          op_q[i] <= inOp;
          {tag_o[i], data_o[i]} <= snoop(inTagO, inDataO);
          {tag_t[i], data_t[i]} <= snoop(inTagT, inDataT);
          tag_w[i] <= inTagW;
          name_w[i] <= inNameW;
        end else if (issue && sel == IDX_W'(i)) busy[i] <= 1'b0;
      end
    end
  end
  // Dispatcher must only target entries it saw free.
  assert property (@(posedge clk) disable iff (!rst) !(inEn && busy[in_idx]));
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: randomized and directed checks of alu_rs against a behavioural reservation-station model.
module tb_alu_rs;
  localparam logic [4:0] FREE = 5'b10000;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic inEn, cdbAluEn, cdbLsEn, outEn;
  logic [5:0] inOp, outOp;
  logic [31:0] inDataO, inDataT, cdbAluData, cdbLsData, outDataO, outDataT;
  logic [4:0] inTagO, inTagT, inTagW, inNameW, cdbAluTag, cdbLsTag, outTagW, outNameW;
  logic [7:0] freeStatus;
  int total = 0, bad = 0;
  alu_rs dut (
    .clk(clk), .rst(rst), .inEn(inEn), .inOp(inOp), .inDataO(inDataO), .inDataT(inDataT),
    .inTagO(inTagO), .inTagT(inTagT), .inTagW(inTagW), .inNameW(inNameW),
    .cdbAluEn(cdbAluEn), .cdbAluTag(cdbAluTag), .cdbAluData(cdbAluData),
    .cdbLsEn(cdbLsEn), .cdbLsTag(cdbLsTag), .cdbLsData(cdbLsData),
`ifdef ALU_RS_FLUSH_EN
    .flush(flush),
`endif
    .freeStatus(freeStatus), .outEn(outEn), .outOp(outOp), .outDataO(outDataO), .outDataT(outDataT),
    .outTagW(outTagW), .outNameW(outNameW)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic v; logic [4:0] t; logic [31:0] d;} opnd_t;
  typedef struct packed {logic busy; logic [5:0] op; opnd_t a; opnd_t b; logic [4:0] tw; logic [4:0] nm;} ent_t;
  ent_t m [8];
  logic e_en;
  logic [5:0] e_op;
  logic [31:0] e_a, e_b;
  logic [4:0] e_tw, e_nm;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic opnd_t wake(input opnd_t x);
    if (!x.v && cdbAluEn && x.t == cdbAluTag) return '{v: 1'b1, t: x.t, d: cdbAluData};
    if (!x.v && cdbLsEn && x.t == cdbLsTag) return '{v: 1'b1, t: x.t, d: cdbLsData};
    return x;
  endfunction
  function automatic logic [7:0] mfree();
    logic [7:0] f;
    for (int i = 0; i < 8; i++) f[i] = !m[i].busy;
    return f;
  endfunction
  task automatic mreset();
    for (int i = 0; i < 8; i++) m[i] = '0;
    e_en = 1'b0; e_op = '0; e_a = '0; e_b = '0; e_tw = FREE; e_nm = '0;
  endtask
  // One clock of the model: oldest-state issue choice, bus wakeup, then dispatch with bypass.
  task automatic model();
    int s = -1;
    opnd_t oa, ob;
    if (flush) begin
      e_en = 1'b0;
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
      return;
    end
    for (int i = 0; i < 8; i++) if (s < 0 && m[i].busy && m[i].a.v && m[i].b.v) s = i;
    e_en = s >= 0;
    if (s >= 0) begin
      e_op = m[s].op; e_a = m[s].a.d; e_b = m[s].b.d; e_tw = m[s].tw; e_nm = m[s].nm;
      m[s].busy = 1'b0;
    end
    for (int i = 0; i < 8; i++) if (m[i].busy) begin
      m[i].a = wake(m[i].a);
      m[i].b = wake(m[i].b);
    end
    if (inEn) begin
      oa = wake('{v: inTagO == FREE, t: inTagO, d: inDataO});
      ob = wake('{v: inTagT == FREE, t: inTagT, d: inDataT});
      m[inTagW[2:0]] = '{busy: 1'b1, op: inOp, a: oa, b: ob, tw: inTagW, nm: inNameW};
    end
  endtask
  task automatic step();
    model();
    @(posedge clk);
    #1;
    chk("outEn", outEn, e_en);
    chk("outOp", outOp, e_op);
    chk("outDataO", outDataO, e_a);
    chk("outDataT", outDataT, e_b);
    chk("outTagW", outTagW, e_tw);
    chk("outNameW", outNameW, e_nm);
    chk("freeStatus", freeStatus, mfree());
  endtask
  task automatic idle();
    inEn = 1'b0; inOp = '0; inDataO = '0; inDataT = '0; inTagO = FREE; inTagT = FREE; inTagW = '0; inNameW = '0;
    cdbAluEn = 1'b0; cdbAluTag = '0; cdbAluData = '0; cdbLsEn = 1'b0; cdbLsTag = '0; cdbLsData = '0;
  endtask
  task automatic disp(input logic [4:0] tw, input logic [4:0] to, input logic [31:0] dO, input logic [4:0] tt,
                      input logic [31:0] dT);
    inEn = 1'b1; inTagW = tw; inTagO = to; inDataO = dO; inTagT = tt; inDataT = dT;
    inOp = 6'($urandom); inNameW = 5'($urandom);
  endtask
  task automatic rand_inputs();
    int fr[$];
    for (int i = 0; i < 8; i++) if (!m[i].busy) fr.push_back(i);
    idle();
    if (fr.size() > 0 && $urandom_range(0, 1) == 1)
      disp({1'b0, 1'($urandom), 3'(fr[$urandom_range(0, fr.size() - 1)])},
           $urandom_range(0, 1) ? FREE : 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) ? FREE : 5'($urandom_range(0, 7)), $urandom);
    cdbAluEn = $urandom_range(0, 2) == 0; cdbAluTag = 5'($urandom_range(0, 7)); cdbAluData = $urandom;
    cdbLsEn = $urandom_range(0, 2) == 0; cdbLsTag = 5'($urandom_range(0, 7)); cdbLsData = $urandom;
    if (cdbLsTag == cdbAluTag) cdbLsTag = cdbAluTag ^ 5'b01000;
  endtask
  initial begin
    int cnt;
    idle();
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_free", freeStatus, 8'hFF);
    chk("rst_outEn", outEn, 0);
    chk("rst_outTagW", outTagW, FREE);
    chk("rst_outData", {outDataO, outDataT}, 64'h0);
    rst = 1'b1;
    disp(5'd3, FREE, 32'd5, FREE, 32'd7);
    step();
    chk("ready_busy3", freeStatus[3], 0);
    idle();
    step();
    chk("ready_en", outEn, 1);
    chk("ready_dataO", outDataO, 5);
    chk("ready_dataT", outDataT, 7);
    chk("ready_tagW", outTagW, 3);
    chk("ready_free3", freeStatus[3], 1);
    disp(5'd0, 5'b01010, 32'd0, FREE, 32'd9);
    step();
    idle(); cdbLsEn = 1'b1; cdbLsTag = 5'b01010; cdbLsData = 32'hDEAD;
    step();
    idle();
    step();
    chk("wake_en", outEn, 1);
    chk("wake_dataO", outDataO, 32'hDEAD);
    disp(5'd0, FREE, 32'd1, 5'b00001, 32'd0);
    cdbAluEn = 1'b1; cdbAluTag = 5'b00001; cdbAluData = 32'd42;
    step();
    idle();
    step();
    chk("bypass_dataT", outDataT, 42);
    disp(5'd2, 5'b01100, 32'd2, FREE, 32'd0);
    step();
    disp(5'd6, 5'b01100, 32'd6, FREE, 32'd0);
    step();
    idle(); cdbAluEn = 1'b1; cdbAluTag = 5'b01100; cdbAluData = 32'h600D;
    step();
    idle();
    step();
    chk("prio_first", outTagW, 2);
    step();
    chk("prio_second", outTagW, 6);
    chk("prio_en", outEn, 1);
    step();
    chk("prio_done", outEn, 0);
    for (int i = 0; i < 8; i++) begin
      disp(5'(i), 5'(8 + i), 32'(i), FREE, 32'(100 + i));
      step();
    end
    idle();
    chk("fill_full", freeStatus, 8'h00);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      idle();
      if (k < 4) begin
        cdbAluEn = 1'b1; cdbAluTag = 5'(8 + 2 * k); cdbAluData = $urandom;
        cdbLsEn = 1'b1; cdbLsTag = 5'(9 + 2 * k); cdbLsData = $urandom;
      end
      step();
      if (outEn) cnt++;
    end
    chk("drain_cnt", cnt, 8);
    chk("drain_free", freeStatus, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      disp(5'(i), 5'b01111, 32'(i), FREE, 32'd0);
      step();
    end
    idle();
    #2 rst = 1'b0;
    #1;
    chk("amid_free", freeStatus, 8'hFF);
    chk("amid_en", outEn, 0);
    chk("amid_tagW", outTagW, FREE);
    mreset();
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    step();
    chk("amid_noissue", outEn, 0);
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
    end
`ifdef ALU_RS_FLUSH_EN
    for (int n = 0; n < 6; n++) begin
      rand_inputs();
      step();
    end
    rand_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_free", freeStatus, 8'hFF);
    chk("flush_en", outEn, 0);
    idle();
    step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
